// File: rtl/ibi_pkg.sv
// ibi_pkg: shared types for the I3C IBI engine.
//   bit_cmd_e   - bit-level command driven into the SCL/SDA modulator
//   ibi_state_e - engine FSM state (encoding fixed, 3 bits)
//   BCAST_ADDR  - broadcast address, never accepted as an IBI source
//   hdr_accept  - ACK decision for a received {addr7, rnw} header
package ibi_pkg;

  typedef enum logic [2:0] {
    CMD_NOP        = 3'd0,
    CMD_START      = 3'd1,
    CMD_STOP       = 3'd2,
    CMD_READ       = 3'd3,
    CMD_WRITE_OD_0 = 3'd4,
    CMD_WRITE_OD_1 = 3'd5,
    CMD_WRITE_PP_0 = 3'd6,
    CMD_WRITE_PP_1 = 3'd7
  } bit_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SETUP = 3'd2,
    ST_ADDR  = 3'd3,
    ST_ACK   = 3'd4,
    ST_DATA  = 3'd5,
    ST_STOP  = 3'd6,
    ST_RSVD  = 3'd7
  } ibi_state_e;

  localparam logic [6:0] BCAST_ADDR = 7'h7F;

  // Header is {addr7, rnw}; only reads from a non-broadcast address at or
  // below the highest assigned dynamic address are accepted.
  function automatic logic hdr_accept(input logic [7:0] hdr, input logic [6:0] hi);
    return hdr[0] && (hdr[7:1] <= hi) && (hdr[7:1] != BCAST_ADDR);
  endfunction

endpackage

// File: rtl/ibi_handler_if.sv
// ibi_handler_if: command-side handshake, SDA pad and received-byte signals
// of the IBI engine.
//   master - the IBI engine (drives SCL/SDA, start_ready, transfer, error)
//   slave  - controller command logic / PHY side (drives start, sda, config)
interface ibi_handler_if;
  logic       i_start;
  logic       o_start_ready;
  logic       i_sda;
  logic       o_scl;
  logic       o_sda;
  logic       o_push_pull_en;
  logic [7:0] i_highest_addr;
  logic       i_bcr_2;
  logic [3:0] i_ab_length;
  logic [7:0] o_transfer;
  logic       o_transfer_valid;
  logic       o_transfer_first;
  logic       o_transfer_last;
  logic       o_error;

  modport master (
    input  i_start, i_sda, i_highest_addr, i_bcr_2, i_ab_length,
    output o_start_ready, o_scl, o_sda, o_push_pull_en,
           o_transfer, o_transfer_valid, o_transfer_first, o_transfer_last, o_error
  );

  modport slave (
    output i_start, i_sda, i_highest_addr, i_bcr_2, i_ab_length,
    input  o_start_ready, o_scl, o_sda, o_push_pull_en,
           o_transfer, o_transfer_valid, o_transfer_first, o_transfer_last, o_error
  );
endinterface

// File: rtl/ibi_bit_mod.sv
// ibi_bit_mod: quarter-phase tick generator and bit-level SCL/SDA modulator.
//   i_clk, i_reset_n - clock, async active-low reset
//   i_cmd            - next bit command, latched at o_cmd_tick
//   i_sda            - bus SDA level, sampled on entry to phase 3
//   o_cmd_tick       - one-cycle pulse at the end of each bit (end of p3)
//   o_rx_bit         - SDA value sampled during the current bit
//   o_scl/o_sda/o_pp_en - pad controls for the current command and phase
module ibi_bit_mod
  import ibi_pkg::*;
#(
  parameter int PHASE_DIV = 4
) (
  input  logic     i_clk,
  input  logic     i_reset_n,
  input  bit_cmd_e i_cmd,
  input  logic     i_sda,
  output logic     o_cmd_tick,
  output logic     o_rx_bit,
  output logic     o_scl,
  output logic     o_sda,
  output logic     o_pp_en
);

  localparam int CW = $clog2(PHASE_DIV);

  logic [CW-1:0] div_q;
  logic [1:0]    phase_q;
  bit_cmd_e      cmd_q;
  logic          rx_q;
  logic          tick;

  assign tick       = (div_q == CW'(PHASE_DIV - 1));
  assign o_cmd_tick = tick && (phase_q == 2'd3);
  assign o_rx_bit   = rx_q;

  // Free-running: bit boundaries stay aligned even while idle, so a request
  // simply waits for the next cmd_tick.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_q   <= '0;
      phase_q <= 2'd0;
      cmd_q   <= CMD_NOP;
      rx_q    <= 1'b1;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) phase_q <= phase_q + 2'd1;
      if (tick && phase_q == 2'd2) rx_q <= i_sda;
      if (o_cmd_tick) cmd_q <= i_cmd;
    end
  end

  // phase_q[1] is the data-bit SCL: low in p0/p1, high in p2/p3.
  always_comb begin
    o_scl   = 1'b1;
    o_sda   = 1'b1;
    o_pp_en = 1'b0;
    case (cmd_q)
      CMD_NOP:        ;
      CMD_START:      o_sda = ~phase_q[1];
      CMD_STOP: begin
        o_scl = phase_q[1];
        o_sda = (phase_q == 2'd3);
      end
      CMD_READ:       o_scl = phase_q[1];
      CMD_WRITE_OD_0: begin o_scl = phase_q[1]; o_sda = 1'b0; end
      CMD_WRITE_OD_1: begin o_scl = phase_q[1]; o_sda = 1'b1; end
      CMD_WRITE_PP_0: begin o_scl = phase_q[1]; o_sda = 1'b0; o_pp_en = 1'b1; end
      CMD_WRITE_PP_1: begin o_scl = phase_q[1]; o_sda = 1'b1; o_pp_en = 1'b1; end
      default:        ;
    endcase
  end

endmodule

// File: rtl/ibi_handler.sv
// ibi_handler: I3C controller-side In-Band-Interrupt engine.
//   i_clk, i_reset_n - clock, async active-low reset
//   bus (master)     - start handshake, SCL/SDA pad controls, target config
//                      (highest address, BCR[2], additional-byte count),
//                      received-byte strobe with first/last, error pulse
// Sequence: START, NOP, 8 READ header bits, ACK/NACK, optional payload
// (MDB + additional bytes, each 8 READ bits + T-bit), STOP.
module ibi_handler
  import ibi_pkg::*;
#(
  parameter int PHASE_DIV = 4
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  ibi_handler_if.master bus
);

  ibi_state_e state_q, state_d;
  logic       pend_q, pend_d;
  logic [7:0] sr_q, sr_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [4:0] byte_cnt_q, byte_cnt_d;
  logic       acc_q, acc_d;
  logic [3:0] ab_q, ab_d;
  logic [7:0] xfer_q, xfer_d;
  logic       valid_q, valid_d;
  logic       first_q, first_d;
  logic       last_q, last_d;
  logic       err_q, err_d;

  bit_cmd_e   cmd;
  logic       cmd_tick;
  logic       rx_bit;

  logic       unused_hi7;
  assign unused_hi7 = bus.i_highest_addr[7];

  ibi_bit_mod #(.PHASE_DIV(PHASE_DIV)) u_bit_mod (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_cmd      (cmd),
    .i_sda      (bus.i_sda),
    .o_cmd_tick (cmd_tick),
    .o_rx_bit   (rx_bit),
    .o_scl      (bus.o_scl),
    .o_sda      (bus.o_sda),
    .o_pp_en    (bus.o_push_pull_en)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      pend_q     <= 1'b0;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      acc_q      <= 1'b0;
      ab_q       <= '0;
      xfer_q     <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      acc_q      <= acc_d;
      ab_q       <= ab_d;
      xfer_q     <= xfer_d;
      valid_q    <= valid_d;
      first_q    <= first_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

  // All state moves happen at cmd_tick; cmd is the command for the bit that
  // starts there, so it is derived together with state_d.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    acc_d      = acc_q;
    ab_d       = ab_q;
    xfer_d     = xfer_q;
    valid_d    = 1'b0;
    first_d    = 1'b0;
    last_d     = 1'b0;
    err_d      = 1'b0;
    cmd        = CMD_NOP;

    if (state_q == ST_IDLE && bus.i_start) pend_d = 1'b1;

    if (cmd_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (pend_q || bus.i_start) begin
            state_d = ST_START;
            pend_d  = 1'b0;
            cmd     = CMD_START;
          end
        end
        ST_START: begin
          state_d = ST_SETUP;
          cmd     = CMD_NOP;
        end
        ST_SETUP: begin
          state_d   = ST_ADDR;
          bit_cnt_d = '0;
          cmd       = CMD_READ;
        end
        ST_ADDR: begin
          sr_d      = {sr_q[6:0], rx_bit};
          bit_cnt_d = bit_cnt_q + 4'd1;
          cmd       = CMD_READ;
          if (bit_cnt_q == 4'd7) begin
            state_d = ST_ACK;
            acc_d   = hdr_accept(sr_d, bus.i_highest_addr[6:0]);
            cmd     = acc_d ? CMD_WRITE_OD_0 : CMD_WRITE_OD_1;
          end
        end
        ST_ACK: begin
          ab_d       = bus.i_ab_length;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          if (acc_q) begin
            valid_d = 1'b1;
            first_d = 1'b1;
            last_d  = ~bus.i_bcr_2;
            xfer_d  = sr_q;
            state_d = bus.i_bcr_2 ? ST_DATA : ST_STOP;
            cmd     = bus.i_bcr_2 ? CMD_READ : CMD_STOP;
          end else begin
            err_d   = 1'b1;
            state_d = ST_STOP;
            cmd     = CMD_STOP;
          end
        end
        ST_DATA: begin
          cmd = CMD_READ;
          if (bit_cnt_q == 4'd8) begin
            // T-bit: byte complete. Ends on count (MDB + ab_length) or when
            // the target signals end-of-data with T=0.
            byte_cnt_d = byte_cnt_q + 5'd1;
            bit_cnt_d  = '0;
            valid_d    = 1'b1;
            xfer_d     = sr_q;
            last_d     = (byte_cnt_d == ({1'b0, ab_q} + 5'd1)) || !rx_bit;
            if (last_d) begin
              state_d = ST_STOP;
              cmd     = CMD_STOP;
            end
          end else begin
            sr_d      = {sr_q[6:0], rx_bit};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          cmd     = CMD_NOP;
        end
        default: begin
          state_d = ST_IDLE;
          cmd     = CMD_NOP;
        end
      endcase
    end
  end

  assign bus.o_start_ready    = (state_q == ST_IDLE);
  assign bus.o_transfer       = xfer_q;
  assign bus.o_transfer_valid = valid_q;
  assign bus.o_transfer_first = first_q;
  assign bus.o_transfer_last  = last_q;
  assign bus.o_error          = err_q;

endmodule

// File: tb/tb_ibi_handler.sv
// tb_ibi_handler: directed IBI scenarios with a scoreboard. Stimulus pushes
// expected strobes; a monitor on the falling clock edge pops and compares,
// and also plays the target (drives i_sda on each SCL fall).
module tb_ibi_handler;
  import ibi_pkg::*;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
    logic       first;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ibi_handler_if ifc();

  ibi_handler #(.PHASE_DIV(4)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (ifc)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   tid   = 0;
  exp_t exp_q[$];
  logic tgt_q[$];
  int   k = 0;
  int   n_start = 0;
  logic ack_sda, ack_pp;
  logic prev_scl = 1'b1, prev_sda = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL t%0d %s: got %0h want %0h", tid, nm, act, exp);
    end
  endtask

  // Scoreboard monitor + target model.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && (ifc.o_transfer_valid || ifc.o_error)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL t%0d unexpected_strobe: got valid=%0b err=%0b data=%0h want none",
                 tid, ifc.o_transfer_valid, ifc.o_error, ifc.o_transfer);
      end else begin
        e = exp_q.pop_front();
        if (e.err)
          chk("err_strobe", {28'd0, ifc.o_transfer_valid, ifc.o_error,
              ifc.o_transfer_first, ifc.o_transfer_last}, 32'b0100);
        else
          chk("xfer_strobe", {20'd0, ifc.o_transfer_valid, ifc.o_error, ifc.o_transfer,
              ifc.o_transfer_first, ifc.o_transfer_last}, {20'd0, 2'b10, e.data, e.first, e.last});
      end
    end
    if (prev_scl && ifc.o_scl && prev_sda && !ifc.o_sda) n_start++;
    if (prev_scl && !ifc.o_scl) begin
      k++;
      ifc.i_sda = (tgt_q.size() > 0) ? tgt_q.pop_front() : 1'b1;
    end
    if (!prev_scl && ifc.o_scl && k == 9) begin
      ack_sda = ifc.o_sda;
      ack_pp  = ifc.o_push_pull_en;
    end
    prev_scl = ifc.o_scl;
    prev_sda = ifc.o_sda;
  end

  task automatic push_byte(input logic [7:0] b, input bit has_t, input logic t);
    for (int i = 7; i >= 0; i--) tgt_q.push_back(b[i]);
    if (has_t) tgt_q.push_back(t);
  endtask

  task automatic exp_x(input logic [7:0] d, input logic f, input logic l);
    exp_q.push_back('{err: 1'b0, data: d, first: f, last: l});
  endtask

  task automatic exp_e();
    exp_q.push_back('{err: 1'b1, data: 8'h00, first: 1'b0, last: 1'b0});
  endtask

  // Target header + released ACK slot.
  task automatic setup_tgt(input logic [7:0] hdr);
    tgt_q.delete();
    push_byte(hdr, 1'b1, 1'b1);
  endtask

  task automatic run_ibi(input int exp_bits, input logic exp_ack, input bit poke);
    int cyc;
    k = 0;
    n_start = 0;
    ack_sda = 1'bx;
    ack_pp  = 1'bx;
    @(negedge clk) ifc.i_start = 1'b1;
    @(negedge clk) ifc.i_start = 1'b0;
    for (int i = 0; i < 40 && ifc.o_start_ready !== 1'b0; i++) @(negedge clk);
    chk("ready_drop", {31'd0, ifc.o_start_ready}, 32'd0);
    cyc = 0;
    while (ifc.o_start_ready !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      ifc.i_start = poke && (cyc == 100);
    end
    ifc.i_start = 1'b0;
    chk("ready_back", {31'd0, ifc.o_start_ready}, 32'd1);
    chk("busy_cycles", cyc, exp_bits * 16);
    repeat (2) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    chk("start_cnt", n_start, 1);
    chk("ack_sda", {31'd0, ack_sda}, {31'd0, exp_ack});
    chk("ack_pp", {31'd0, ack_pp}, 32'd0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    ifc.i_start        = 1'b0;
    ifc.i_sda          = 1'b1;
    ifc.i_highest_addr = 8'h7F;
    ifc.i_bcr_2        = 1'b0;
    ifc.i_ab_length    = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ifc.o_start_ready}, 32'd1);
    chk("rst_scl_sda_pp", {29'd0, ifc.o_scl, ifc.o_sda, ifc.o_push_pull_en}, 32'b110);
    chk("rst_xfer", {20'd0, ifc.o_transfer, ifc.o_transfer_valid, ifc.o_transfer_first,
        ifc.o_transfer_last, ifc.o_error}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // t1: idle bus -> header 0xFF (broadcast) rejected
    tid = 1; tgt_q.delete(); exp_e();
    run_ibi(12, 1'b1, 1'b0);

    // t2: header 0x05, no payload
    tid = 2; setup_tgt(8'h05); exp_x(8'h05, 1'b1, 1'b1);
    run_ibi(12, 1'b0, 1'b0);
    chk("xfer_hold", {24'd0, ifc.o_transfer}, 32'h05);

    // t3: payload MDB + 3, all T=1, plus an ignored start while busy
    tid = 3; ifc.i_bcr_2 = 1'b1; ifc.i_ab_length = 4'd3;
    setup_tgt(8'h05);
    push_byte(8'hA1, 1'b1, 1'b1); push_byte(8'hB2, 1'b1, 1'b1);
    push_byte(8'hC3, 1'b1, 1'b1); push_byte(8'hD4, 1'b1, 1'b1);
    exp_x(8'h05, 1'b1, 1'b0); exp_x(8'hA1, 1'b0, 1'b0); exp_x(8'hB2, 1'b0, 1'b0);
    exp_x(8'hC3, 1'b0, 1'b0); exp_x(8'hD4, 1'b0, 1'b1);
    run_ibi(12 + 4 * 9, 1'b0, 1'b1);
    repeat (64) @(negedge clk);
    chk("busy_start_ignored", {31'd0, ifc.o_start_ready}, 32'd1);
    chk("busy_no_frame", n_start, 1);

    // t4: target ends early with T=0 on second data byte
    tid = 4;
    setup_tgt(8'h05);
    push_byte(8'hA1, 1'b1, 1'b1); push_byte(8'hB2, 1'b1, 1'b0); push_byte(8'hC3, 1'b1, 1'b1);
    exp_x(8'h05, 1'b1, 1'b0); exp_x(8'hA1, 1'b0, 1'b0); exp_x(8'hB2, 1'b0, 1'b1);
    run_ibi(12 + 2 * 9, 1'b0, 1'b0);

    // t5: addr 0x02 above highest 0x01 -> NACK
    tid = 5; ifc.i_highest_addr = 8'h01; ifc.i_bcr_2 = 1'b0;
    setup_tgt(8'h05); exp_e();
    run_ibi(12, 1'b1, 1'b0);

    // t6: rnw=0 header -> NACK
    tid = 6; ifc.i_highest_addr = 8'h7F;
    setup_tgt(8'h04); exp_e();
    run_ibi(12, 1'b1, 1'b0);

    // t7: addr equal to highest (bit7 of highest ignored) accepted
    tid = 7; ifc.i_highest_addr = 8'hBF;
    setup_tgt(8'h7F); exp_x(8'h7F, 1'b1, 1'b1);
    run_ibi(12, 1'b0, 1'b0);

    // t8: ab_length=0 -> single MDB with last set by count
    tid = 8; ifc.i_highest_addr = 8'h7F; ifc.i_bcr_2 = 1'b1; ifc.i_ab_length = 4'd0;
    setup_tgt(8'h0B); push_byte(8'h3C, 1'b1, 1'b1);
    exp_x(8'h0B, 1'b1, 1'b0); exp_x(8'h3C, 1'b0, 1'b1);
    run_ibi(12 + 9, 1'b0, 1'b0);

    // t9: async reset during DATA, then a full IBI
    tid = 9; ifc.i_ab_length = 4'd3;
    setup_tgt(8'h05);
    push_byte(8'hA1, 1'b1, 1'b1); push_byte(8'hB2, 1'b1, 1'b1);
    exp_x(8'h05, 1'b1, 1'b0);
    @(negedge clk) ifc.i_start = 1'b1;
    @(negedge clk) ifc.i_start = 1'b0;
    repeat (300) @(negedge clk);
    chk("pre_rst_sb", exp_q.size(), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, ifc.o_start_ready}, 32'd1);
    chk("arst_scl_sda_pp", {29'd0, ifc.o_scl, ifc.o_sda, ifc.o_push_pull_en}, 32'b110);
    chk("arst_xfer", {20'd0, ifc.o_transfer, ifc.o_transfer_valid, ifc.o_transfer_first,
        ifc.o_transfer_last, ifc.o_error}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tid = 10;
    setup_tgt(8'h05);
    push_byte(8'hA1, 1'b1, 1'b1); push_byte(8'hB2, 1'b1, 1'b1);
    push_byte(8'hC3, 1'b1, 1'b1); push_byte(8'hD4, 1'b1, 1'b1);
    exp_x(8'h05, 1'b1, 1'b0); exp_x(8'hA1, 1'b0, 1'b0); exp_x(8'hB2, 1'b0, 1'b0);
    exp_x(8'hC3, 1'b0, 1'b0); exp_x(8'hD4, 1'b0, 1'b1);
    run_ibi(12 + 4 * 9, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ibi_handler.md
Name: ibi_handler

Overview:
- I3C controller-side In-Band-Interrupt (IBI) engine. On request it issues START, clocks in the target's address header and ACKs or NACKs it. If accepted, it reads the Mandatory Data Byte plus additional bytes, then issues STOP.
- Integrates the FSM, a quarter-phase tick generator and a bit-level SCL/SDA modulator.
- Sits between the controller command logic and the SDA pad (open-drain/push-pull PHY).

Parameters:
- PHASE_DIV, 4, i_clk cycles per quarter-bit phase (≥2). One SCL bit = 4 phases = 16 i_clk by default.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  reset, asynchronous, active-low
- i_start  in  1  IBI service request; accepted only while o_start_ready=1
- o_start_ready  out  1  high in IDLE
- i_sda  in  1  sampled SDA bus level
- o_scl  out  1  SCL
- o_sda  out  1  SDA drive value (0=drive low, 1=release when open-drain)
- o_push_pull_en  out  1  1=push-pull, 0=open-drain
- i_highest_addr  in  8  bits[6:0] = highest accepted dynamic address; bit7 ignored
- i_bcr_2  in  1  target has IBI payload (BCR[2]); sampled at ACK bit end
- i_ab_length  in  4  number of additional bytes after MDB; sampled with i_bcr_2
- o_transfer  out  8  received byte
- o_transfer_valid  out  1  one-cycle strobe
- o_transfer_first  out  1  qualifies the valid strobe: address byte
- o_transfer_last  out  1  qualifies the valid strobe: final byte
- o_error  out  1  one-cycle pulse on rejected IBI

Behaviour:
- Reset:
  - FSM=IDLE; o_scl=1, o_sda=1, o_push_pull_en=0.
  - o_start_ready=1; all transfer outputs=0; o_error=0; counters=0.
- Phase tick: one-cycle pulse every PHASE_DIV i_clk.
- Bit phases:
  - p0: SCL low, SDA updated.
  - p1: SCL low.
  - p2: SCL rises.
  - p3: SCL high; i_sda sampled at p3 entry.
  - cmd_tick pulses at end of p3; the next command is latched there.
- Bit commands (package enum):
  - NOP: SCL high, SDA released.
  - START: SDA falls while SCL high.
  - STOP: SDA low then rises while SCL high.
  - READ: OD, SDA released, sample.
  - WRITE_OD_0 / WRITE_OD_1.
  - WRITE_PP_0 / WRITE_PP_1, the only commands with push_pull_en=1.
- FSM (3-bit encoding fixed):
  - 0 IDLE: o_start_ready=1; i_start → 1 at the next phase-aligned bit boundary.
  - 1 START: one START bit → 2.
  - 2 SETUP: one NOP bit → 3.
  - 3 ADDR: 8 READ bits, MSB first, into shift reg {addr7,rnw} → 4.
  - 4 ACK: one bit.
    - Accept iff rnw=1 AND addr7≤i_highest_addr[6:0] AND addr7≠7'h7F.
    - Accept: WRITE_OD_0. Reject: WRITE_OD_1.
    - At the ACK cmd_tick, sample i_bcr_2/i_ab_length.
    - Accept: emit the address byte (valid=1, first=1, last=!bcr_2). Go to 5 if bcr_2, else 6.
    - Reject: no transfer, o_error=1 for one cycle → 6.
  - 5 DATA: per byte, 8 READ bits + 1 READ T-bit.
    - At the T-bit cmd_tick emit the byte (first=0).
    - last=1 if byte count = ab_length+1 or T-bit sampled 0 (target end).
    - last → 6, else next byte.
  - 6 STOP: one STOP bit → 0.
  - 7: unreachable; → 0.
- i_start while not ready is ignored; no queuing.
- Only one of o_transfer_valid/o_error per cycle.
- o_transfer holds its value until the next strobe.
- Reset mid-transfer aborts immediately to reset values; the bus is released with SCL=1, SDA=1. No STOP is issued.
- Byte counter is 5 bits: max 16 bytes after the address.

Decomposition:
- Package ibi_pkg: bit-command enum (NOP, START, STOP, READ, WRITE_OD_0/1, WRITE_PP_0/1), FSM state enum, broadcast constant 7'h7F.
- One sub-module: ibi_bit_mod, containing the phase tick counter + command→SCL/SDA modulator with cmd_tick. FSM stays in top.

Test Plan:
- Idle bus (i_sda=1 throughout), i_start pulse: addr 0x7F is rejected with WRITE_OD_1. Required: o_error pulse, no o_transfer_valid, STOP, o_start_ready=1 after ~12 bits (192 i_clk).
- Target drives 8'h05 in ADDR, highest=0x7F, bcr_2=0: ACK low at p3 of bit 4. Required: one strobe o_transfer=0x05 with first=1, last=1, then STOP.
- As previous case but bcr_2=1, ab_length=3 set during ACK, target supplies 0xA1,0xB2,0xC3,0xD4 with T=1: five strobes in total. Required: 0x05 (first), then the four data bytes in order; last only on 0xD4.
- Same as previous case but T-bit=0 after the second data byte. Required: last asserted on that byte, then STOP; no further bytes.
- Address 8'h05 with highest=0x01: addr 0x02 is rejected. Required: NACK, o_error, no transfer. Separately, header 8'h04 (rnw=0) is also rejected.
- Assert i_reset_n low during DATA: outputs return to reset values asynchronously. Required: a fresh i_start afterwards runs a full IBI correctly. Also check that i_start while busy is ignored.
